// File: rtl/mul_pipe_pkg.sv
// mul_pipe_pkg: widths shared by the 4x4 sequential multiplier and its result collector.
//   PROD_W : product width (two OPND_W operands multiplied)
//   OPND_W : multiplier operand width
//   prod_t : one product word
package mul_pipe_pkg;
   localparam int OPND_W = 4;
   localparam int PROD_W = 2 * OPND_W;
   typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-based FIFO with wrap-bit pointers and a combinational head read.
//   clk, reset : clock and asynchronous active-high reset (empties the FIFO, clears storage)
//   i_push     : write i_data this cycle (caller guarantees room, counting a same-cycle pop)
//   i_pop      : retire the head this cycle (caller guarantees o_valid)
//   i_data     : word to write
//   o_data     : current head word, held steady until popped
//   o_valid    : FIFO not empty
//   o_full     : FIFO holds DEPTH words
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage is cleared on reset so the head never presents X, even while empty.
   // When full, a push and pop in the same cycle hit the same slot; the head is
   // read before the edge, so overwriting it is safe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr <= r_wr + (AW+1)'(1);
         end
         if (i_pop) r_rd <= r_rd + (AW+1)'(1);
      end
   end

   assign o_data  = r_mem[r_rd[AW-1:0]];
   assign o_valid = r_wr != r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

// File: rtl/mul_result_collector.sv
// mul_result_collector: captures multiplier products on done edges into a FIFO stream,
// keeping a saturating running sum and a count of products dropped on a full FIFO.
//   clk, reset : clock and asynchronous active-high reset (discards everything)
//   prod_in    : product, valid while prod_done is high
//   prod_done  : multiplier done level; only its rising edge captures a product
//   acc_clear  : synchronous clear of acc_sum/acc_sat, taking priority over the add
//   out_ready  : downstream accepts out_data this cycle
//   out_valid  : FIFO head valid
//   out_data   : FIFO head product
//   acc_sum    : saturating sum of accepted products
//   acc_sat    : sticky saturation flag
//   fifo_full  : FIFO holds DEPTH entries
//   drop_cnt   : products lost to a full FIFO, saturating at all-ones
module mul_result_collector
   import mul_pipe_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ACC_W  = 12,
   parameter int DROP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_done,
   input  logic              acc_clear,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [PROD_W-1:0] out_data,
   output logic [ACC_W-1:0]  acc_sum,
   output logic              acc_sat,
   output logic              fifo_full,
   output logic [DROP_W-1:0] drop_cnt
);
   logic              r_done_q;
   logic [ACC_W-1:0]  r_acc;
   logic              r_sat;
   logic [DROP_W-1:0] r_drop;

   logic              w_push_req;
   logic              w_pop;
   logic              w_push_ok;
   logic [ACC_W:0]    w_base;
   logic [ACC_W:0]    w_sum;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic              w_sat_nxt;
   logic [DROP_W-1:0] w_drop_nxt;

   assign w_push_req = prod_done & ~r_done_q;
   assign w_pop      = out_valid & out_ready;
   // A pop frees its slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign w_push_ok  = w_push_req & (~fifo_full | w_pop);

   // Clear wins over the running value: a same-cycle push restarts the sum from its product.
   assign w_base    = acc_clear ? '0 : {1'b0, r_acc};
   assign w_sum     = w_base + {{(ACC_W+1-PROD_W){1'b0}}, prod_in};
   assign w_acc_nxt = w_push_ok ? (w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0]) : w_base[ACC_W-1:0];
   assign w_sat_nxt = (acc_clear ? 1'b0 : r_sat) | (w_push_ok & w_sum[ACC_W]);

   assign w_drop_nxt = (w_push_req & ~w_push_ok & ~&r_drop) ? r_drop + DROP_W'(1) : r_drop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done_q <= 1'b0;
         r_acc    <= '0;
         r_sat    <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_done_q <= prod_done;
         r_acc    <= w_acc_nxt;
         r_sat    <= w_sat_nxt;
         r_drop   <= w_drop_nxt;
      end
   end

   sync_fifo #(
      .WIDTH(PROD_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_push_ok),
      .i_pop  (w_pop),
      .i_data (prod_in),
      .o_data (out_data),
      .o_valid(out_valid),
      .o_full (fifo_full)
   );

   assign acc_sum  = r_acc;
   assign acc_sat  = r_sat;
   assign drop_cnt = r_drop;
endmodule

// File: tb/tb_mul_result_collector.sv
// tb_mul_result_collector: table-driven checks of the collector plus saturation and async-reset sequences.
module tb_mul_result_collector;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  prod_in;
   logic        prod_done;
   logic        acc_clear;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [11:0] acc_sum;
   logic        acc_sat;
   logic        fifo_full;
   logic [3:0]  drop_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        d;
      logic [7:0]  p;
      logic        c;
      logic        r;
      logic        v;
      logic [7:0]  dat;
      logic [11:0] sum;
      logic        full;
      logic [3:0]  drop;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   mul_result_collector #(.DEPTH(4), .ACC_W(12), .DROP_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .prod_in  (prod_in),
      .prod_done(prod_done),
      .acc_clear(acc_clear),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .acc_sum  (acc_sum),
      .acc_sat  (acc_sat),
      .fifo_full(fifo_full),
      .drop_cnt (drop_cnt)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic add(input logic d, input logic [7:0] p, input logic c, input logic r,
                      input logic v, input logic [7:0] dat, input logic [11:0] sum,
                      input logic full, input logic [3:0] drop);
      tbl.push_back(vec_t'{d, p, c, r, v, dat, sum, full, drop});
   endtask

   // Drive inputs just after an edge, then sample 1 time unit after the next edge.
   task automatic step(input logic d, input logic [7:0] p, input logic c, input logic r);
      prod_done = d;
      prod_in   = p;
      acc_clear = c;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      prod_in = '0;
      prod_done = 1'b0;
      acc_clear = 1'b0;
      out_ready = 1'b0;
      //  d  prod  c  r  | v  data   sum     full drop
      add(1, 8'h2D, 0, 0, 1, 8'h2D, 12'd45, 0, 4'd0);
      add(0, 8'h00, 0, 1, 0, 8'h00, 12'd45, 0, 4'd0);
      add(1, 8'h0F, 0, 0, 1, 8'h0F, 12'd60, 0, 4'd0);
      add(1, 8'h0F, 0, 0, 1, 8'h0F, 12'd60, 0, 4'd0);
      add(1, 8'h0F, 0, 0, 1, 8'h0F, 12'd60, 0, 4'd0);
      add(0, 8'h00, 0, 1, 0, 8'h00, 12'd60, 0, 4'd0);
      add(1, 8'h01, 1, 0, 1, 8'h01, 12'd1,  0, 4'd0);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd1,  0, 4'd0);
      add(1, 8'h01, 0, 0, 1, 8'h01, 12'd2,  0, 4'd0);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd2,  0, 4'd0);
      add(1, 8'h01, 0, 0, 1, 8'h01, 12'd3,  0, 4'd0);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd3,  0, 4'd0);
      add(1, 8'h01, 0, 0, 1, 8'h01, 12'd4,  1, 4'd0);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd4,  1, 4'd0);
      add(1, 8'h01, 0, 0, 1, 8'h01, 12'd4,  1, 4'd1);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd4,  1, 4'd1);
      add(1, 8'h01, 0, 0, 1, 8'h01, 12'd4,  1, 4'd2);
      add(0, 8'h00, 0, 0, 1, 8'h01, 12'd4,  1, 4'd2);
      add(1, 8'h09, 0, 1, 1, 8'h01, 12'd13, 1, 4'd2);
      add(0, 8'h00, 0, 1, 1, 8'h01, 12'd13, 0, 4'd2);
      add(0, 8'h00, 0, 1, 1, 8'h01, 12'd13, 0, 4'd2);
      add(0, 8'h00, 0, 1, 1, 8'h09, 12'd13, 0, 4'd2);
      add(0, 8'h00, 0, 1, 0, 8'h00, 12'd13, 0, 4'd2);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data",  32'(out_data),  0);
      chk("rst_sum",   32'(acc_sum),   0);
      chk("rst_sat",   32'(acc_sat),   0);
      chk("rst_full",  32'(fifo_full), 0);
      chk("rst_drop",  32'(drop_cnt),  0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         step(tbl[i].d, tbl[i].p, tbl[i].c, tbl[i].r);
         chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
         if (tbl[i].v) chk($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].dat));
         chk($sformatf("row%0d_sum", i),  32'(acc_sum),   32'(tbl[i].sum));
         chk($sformatf("row%0d_sat", i),  32'(acc_sat),   0);
         chk($sformatf("row%0d_full", i), 32'(fifo_full), 32'(tbl[i].full));
         chk($sformatf("row%0d_drop", i), 32'(drop_cnt),  32'(tbl[i].drop));
      end

      // 225 x 18 = 4050 still fits in 12 bits; the 19th push overflows.
      for (int i = 0; i < 19; i++) begin
         step(1'b1, 8'hE1, i == 0, 1'b1);
         if (i == 17) begin
            chk("sat_pre_sum", 32'(acc_sum), 4050);
            chk("sat_pre_flag", 32'(acc_sat), 0);
         end
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("sat_sum",  32'(acc_sum), 32'hFFF);
      chk("sat_flag", 32'(acc_sat), 1);
      step(1'b1, 8'h01, 1'b0, 1'b1);
      chk("sat_hold_sum",  32'(acc_sum), 32'hFFF);
      chk("sat_hold_flag", 32'(acc_sat), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h05, 1'b1, 1'b1);
      chk("clr_push_sum",  32'(acc_sum), 5);
      chk("clr_push_flag", 32'(acc_sat), 0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("clr_only_sum", 32'(acc_sum), 0);
      chk("clr_keep_drop", 32'(drop_cnt), 2);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h07, 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_sum",   32'(acc_sum),   21);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_sum",   32'(acc_sum),   0);
      chk("arst_drop",  32'(drop_cnt),  0);
      chk("arst_full",  32'(fifo_full), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("post_rst_valid", 32'(out_valid), 0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("post_rst_data", 32'(out_data), 32'h3C);
      chk("post_rst_sum",  32'(acc_sum),  60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
